demux1t4_5_buf: RTL and testbench
=================================

Name: demux1t4_5_buf

Overview:
- Registered 1-to-4 distributor for 5-bit register-address/ID values.
- One input stream, steered by a 2-bit select into one of four independent single-entry output slots, each with its own valid/ready handshake.
- Used in the multicycle CPU where one producer feeds one of four consumers (write-back stages, debug taps).
- Keeps per-channel saturating transfer counters for debug display.

Parameters:
- WIDTH, 5, data width of input and each output channel.
- CNT_W, 8, width of each per-channel transfer counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i  input  WIDTH  input data.
- s  input  2  destination channel select (0..3).
- i_valid  input  1  input data valid.
- i_ready  output  1  block can accept input to channel s this cycle.
- o0, o1, o2, o3  output  WIDTH each  registered slot data, channels 0..3.
- o_valid  output  4  bit k = slot k holds unconsumed data.
- o_ready  input  4  bit k = consumer k takes slot k this cycle.
- clr_cnt  input  1  synchronous clear of all transfer counters.
- cnt0, cnt1, cnt2, cnt3  output  CNT_W each  accepted-transfer count per channel.

Behaviour:
- Reset (async, rst=1): all slot data, o_valid and counters are 0 immediately and stay 0 while rst is high. Pending slot data is discarded. No partial state survives a reset asserted mid-operation.
- i_ready is combinational: i_ready = ~o_valid[s] | o_ready[s]. It depends only on the selected slot; other slots never block the input.
- Accept: occurs when i_valid & i_ready on a clock edge. Slot s loads i, and o_valid[s]=1 from the next cycle (latency 1).
- Drain: when o_valid[k] & o_ready[k] and no accept targets k, o_valid[k] clears next cycle. Slot data holds its last value after drain; o_k is defined even when invalid.
- Simultaneous drain and accept on the same slot: new data loads and o_valid[k] stays 1. This is full throughput, one transfer per cycle per slot.
- Stall: o_valid[k]=1 and o_ready[k]=0 means o_k is held stable until consumed.
- Slot independence: each slot drains independently. Accept into slot j does not alter any other slot's data or valid in the same cycle.
- o_ready[k] while o_valid[k]=0 is ignored.
- Input side has no stability requirement. The producer may change s or i, or drop i_valid, while i_ready=0; nothing is captured in that case.
- i_valid=0: no slot loads, regardless of s.
- Counters: cnt_k increments by 1 on each accept into slot k and saturates at 2^CNT_W-1 (no wrap).
- clr_cnt=1 zeroes all counters on that edge and overrides any increment that same cycle. Slot data and valid are unaffected.
- Implementation: per slot, WIDTH-bit data register plus 1 valid flop; four CNT_W counters. No combinational path from i to any output.

Test Plan:
- Reset release, i_valid=0 -> o_valid=4'b0000, o0..o3=0, cnt0..cnt3=0, i_ready=1 for every s.
- i=5'd17, s=2, i_valid=1 for one cycle, o_ready=0 -> next cycle o_valid=4'b0100, o2=17. i_ready=0 while s=2, 1 while s=0.
- Slot 2 full, o_ready[2]=1, and same cycle i=5'd9, s=2, i_valid=1 -> o2=9, o_valid[2] stays 1, cnt2 increments.
- Stream 300 accepts into slot 1 with o_ready[1]=1 every cycle -> one accept per cycle, cnt1 saturates at 255. clr_cnt pulsed during an accept -> cnt1=0 next cycle.
- Fill slots 0 and 3 (i=5'd1, 5'd31), hold o_ready=0 for 10 cycles -> o0=1, o3=31 held stable. Then o_ready=4'b1000 -> only o_valid[3] clears.
- Assert rst asynchronously mid-cycle with all four slots valid -> o_valid=0 and counters=0 before the next clk edge. Post-reset behaviour matches the first scenario.

Source files
------------

// File: rtl/demux1t4_5_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux1t4_5_buf : registered 1-to-4 distributor with per-slot valid/ready
//                  handshakes and saturating per-channel transfer counters.
// Revision 1.0
// ---------------------------------------------------------------------------
module demux1t4_5_buf #(
   parameter int WIDTH = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i,
   input  logic [1:0]       s,
   input  logic             i_valid,
   output logic             i_ready,
   output logic [WIDTH-1:0] o0,
   output logic [WIDTH-1:0] o1,
   output logic [WIDTH-1:0] o2,
   output logic [WIDTH-1:0] o3,
   output logic [3:0]       o_valid,
   input  logic [3:0]       o_ready,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic [CNT_W-1:0] cnt3
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] r_data [4];
   logic [CNT_W-1:0] r_cnt  [4];
   logic [3:0]       r_valid;
   logic [3:0]       w_load;
   logic             w_accept;

   // Readiness looks only at the selected slot; a full slot that is being
   // drained this cycle can still take new data.
   assign i_ready  = ~r_valid[s] | o_ready[s];
   assign w_accept = i_valid & i_ready;

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_slot
         assign w_load[g] = w_accept & (s == 2'(g));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_data[g]  <= '0;
               r_valid[g] <= 1'b0;
            end else if (w_load[g]) begin
               r_data[g]  <= i;
               r_valid[g] <= 1'b1;
            end else if (o_ready[g]) begin
               r_valid[g] <= 1'b0;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_cnt[g] <= '0;
            end else if (clr_cnt) begin
               r_cnt[g] <= '0;
            end else if (w_load[g] && (r_cnt[g] != c_CNT_MAX)) begin
               r_cnt[g] <= r_cnt[g] + 1'b1;
            end
         end
      end
   endgenerate

   assign o0      = r_data[0];
   assign o1      = r_data[1];
   assign o2      = r_data[2];
   assign o3      = r_data[3];
   assign o_valid = r_valid;
   assign cnt0    = r_cnt[0];
   assign cnt1    = r_cnt[1];
   assign cnt2    = r_cnt[2];
   assign cnt3    = r_cnt[3];

endmodule
`default_nettype wire

// File: tb/tb_demux1t4_5_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_demux1t4_5_buf : directed stimulus with a scoreboard monitor for the
//                     1-to-4 registered distributor.
// ---------------------------------------------------------------------------
module tb_demux1t4_5_buf;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] i = '0;
   logic [1:0] s = '0;
   logic       i_valid = 1'b0;
   logic       i_ready;
   logic [4:0] o0, o1, o2, o3;
   logic [3:0] o_valid;
   logic [3:0] o_ready = '0;
   logic       clr_cnt = 1'b0;
   logic [7:0] cnt0, cnt1, cnt2, cnt3;

   int checks   = 0;
   int failures = 0;

   demux1t4_5_buf #(.WIDTH(5), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .i(i), .s(s), .i_valid(i_valid), .i_ready(i_ready),
      .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o_valid(o_valid), .o_ready(o_ready),
      .clr_cnt(clr_cnt), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
   );

   always #5 clk = ~clk;

   logic [4:0] w_o   [4];
   logic [7:0] w_cnt [4];
   assign w_o[0] = o0;   assign w_o[1] = o1;   assign w_o[2] = o2;   assign w_o[3] = o3;
   assign w_cnt[0] = cnt0; assign w_cnt[1] = cnt1; assign w_cnt[2] = cnt2; assign w_cnt[3] = cnt3;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard state: expected data queued per slot, last loaded data, counters.
   logic [4:0] q_exp [4][$];
   logic [4:0] m_data [4] = '{default: '0};
   int         m_cnt  [4] = '{default: 0};
   logic       m_ready;
   logic       m_drain;

   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            q_exp[k].delete();
            m_data[k] = '0;
            m_cnt[k]  = 0;
         end
      end else begin
         m_ready = (q_exp[s].size() == 0) || o_ready[s];
         chk("i_ready", int'(i_ready), int'(m_ready));
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("o_valid[%0d]", k), int'(o_valid[k]), int'(q_exp[k].size() != 0));
            chk($sformatf("o%0d", k), int'(w_o[k]), int'(m_data[k]));
            chk($sformatf("cnt%0d", k), int'(w_cnt[k]), m_cnt[k]);
         end
         for (int k = 0; k < 4; k++) begin
            m_drain = (q_exp[k].size() != 0) && o_ready[k];
            if (m_drain)
               chk($sformatf("drain%0d", k), int'(w_o[k]), int'(q_exp[k].pop_front()));
            if (i_valid && m_ready && (int'(s) == k)) begin
               q_exp[k].push_back(i);
               m_data[k] = i;
               if (!clr_cnt && m_cnt[k] != 255) m_cnt[k]++;
            end
            if (clr_cnt) m_cnt[k] = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_o_valid"}, int'(o_valid), 0);
      chk({tag, "_cnt_sum"}, int'(cnt0) + int'(cnt1) + int'(cnt2) + int'(cnt3), 0);
      chk({tag, "_o_sum"}, int'(o0) + int'(o1) + int'(o2) + int'(o3), 0);
      for (int k = 0; k < 4; k++) begin
         s = 2'(k);
         #1;
         chk($sformatf("%s_i_ready_s%0d", tag, k), int'(i_ready), 1);
      end
   endtask

   initial begin
      // Reset release with nothing offered
      repeat (2) tick();
      rst = 1'b0;
      tick();
      check_idle("reset");

      // Single accept into slot 2, consumer stalled
      i = 5'd17; s = 2'd2; i_valid = 1'b1; o_ready = 4'b0000;
      tick();
      i_valid = 1'b0;
      chk("s2_o_valid", int'(o_valid), 4'b0100);
      chk("s2_o2", int'(o2), 17);
      s = 2'd2; #1; chk("s2_ready_sel2", int'(i_ready), 0);
      s = 2'd0; #1; chk("s2_ready_sel0", int'(i_ready), 1);
      tick();

      // Simultaneous drain and accept on slot 2
      o_ready = 4'b0100; i = 5'd9; s = 2'd2; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      chk("thru_o2", int'(o2), 9);
      chk("thru_o_valid", int'(o_valid), 4'b0100);
      chk("thru_cnt2", int'(cnt2), 2);
      tick();
      chk("drain_o_valid", int'(o_valid), 0);
      chk("drain_o2_hold", int'(o2), 9);
      o_ready = 4'b0000;

      // 300-beat stream into slot 1, counter saturation, then clear during accept
      s = 2'd1; o_ready = 4'b0010; i_valid = 1'b1;
      for (int n = 0; n < 300; n++) begin
         i = 5'(n);
         tick();
      end
      chk("sat_cnt1", int'(cnt1), 255);
      i = 5'd3; clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0; i_valid = 1'b0;
      chk("clr_cnt1", int'(cnt1), 0);
      chk("clr_cnt2", int'(cnt2), 0);
      chk("clr_o1", int'(o1), 3);
      tick();
      o_ready = 4'b0000;

      // Stall slots 0 and 3, then release only slot 3
      i = 5'd1; s = 2'd0; i_valid = 1'b1;
      tick();
      i = 5'd31; s = 2'd3;
      tick();
      i_valid = 1'b0;
      repeat (10) tick();
      chk("stall_o0", int'(o0), 1);
      chk("stall_o3", int'(o3), 31);
      chk("stall_o_valid", int'(o_valid), 4'b1001);
      o_ready = 4'b1000;
      tick();
      chk("rel3_o_valid", int'(o_valid), 4'b0001);
      o_ready = 4'b0000;

      // Fill all slots, then assert reset between clock edges
      i_valid = 1'b1;
      i = 5'd5; s = 2'd1; tick();
      i = 5'd6; s = 2'd2; tick();
      i = 5'd7; s = 2'd3; tick();
      i_valid = 1'b0;
      chk("full_o_valid", int'(o_valid), 4'b1111);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_o_valid", int'(o_valid), 0);
      chk("async_cnt3", int'(cnt3), 0);
      chk("async_o3", int'(o3), 0);
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      tick();
      check_idle("post_reset");
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
